// File: rtl/int_pow_unit.sv
// ---------------------------------------------------------------------------
// int_pow_unit
//
// Iterative unsigned exponentiation: result_out = base_in ** exp_in mod
// 2^WIDTH. It uses right-to-left square-and-multiply and retires one exponent
// bit per cycle. overflow_out flags that the true result needs more than
// WIDTH bits.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      request present            in_ready   unit idle, can accept
//   base_in       unsigned base (WIDTH)      exp_in     unsigned exponent
//   out_valid     result present             out_ready  consumer accepts result
//   result_out    base**exp mod 2^WIDTH      overflow_out  true result >= 2^WIDTH
//
// Latency: the accept edge enters RUN. There are n = clog2(exp+1) bit edges
// plus one final edge into DONE, so out_valid rises n+1 cycles after accept.
// ---------------------------------------------------------------------------
module int_pow_unit #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     base_in,
    input  logic [EXP_WIDTH-1:0] exp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result_out,
    output logic                 overflow_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [WIDTH-1:0]       acc_reg;
    logic [WIDTH-1:0]       sq_reg;
    logic [EXP_WIDTH-1:0]   e_reg;
    logic                   acc_ovf_reg;
    logic                   sq_ovf_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;
    logic [WIDTH-1:0]       result_reg;
    logic                   overflow_reg;

    // Full double-width products. The upper halves detect overflow.
    logic [2*WIDTH-1:0]     acc_prod;
    logic [2*WIDTH-1:0]     sq_prod;
    logic                   acc_prod_hi;
    logic                   sq_prod_hi;

    assign acc_prod    = {{WIDTH{1'b0}}, acc_reg} * {{WIDTH{1'b0}}, sq_reg};
    assign sq_prod     = {{WIDTH{1'b0}}, sq_reg}  * {{WIDTH{1'b0}}, sq_reg};
    assign acc_prod_hi = |acc_prod[2*WIDTH-1:WIDTH];
    assign sq_prod_hi  = |sq_prod[2*WIDTH-1:WIDTH];

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign result_out   = result_reg;
    assign overflow_out = overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            sq_reg        <= '0;
            e_reg         <= '0;
            acc_ovf_reg   <= 1'b0;
            sq_ovf_reg    <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        acc_reg      <= {{(WIDTH-1){1'b0}}, 1'b1};
                        sq_reg       <= base_in;
                        e_reg        <= exp_in;
                        acc_ovf_reg  <= 1'b0;
                        sq_ovf_reg   <= 1'b0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= S_RUN;
                    end else begin
                        // This also raises in_ready on the first edge after reset.
                        in_ready_reg <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (e_reg != '0) begin
                        if (e_reg[0]) begin
                            acc_reg <= acc_prod[WIDTH-1:0];
                            // A wrapped square only matters once it is multiplied
                            // into a nonzero accumulator.
                            acc_ovf_reg <= acc_ovf_reg | acc_prod_hi |
                                           (sq_ovf_reg & (acc_reg != '0));
                        end
                        sq_reg     <= sq_prod[WIDTH-1:0];
                        sq_ovf_reg <= sq_ovf_reg | sq_prod_hi;
                        e_reg      <= e_reg >> 1;
                    end else begin
                        result_reg    <= acc_reg;
                        overflow_reg  <= acc_ovf_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end

                default: begin
                    state_reg     <= S_IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
